// File: rtl/pwm_note_sequencer_n.sv
// pwm_note_sequencer_n
// Programmable note sequencer feeding the PWM/NCO synth voice. A writable step
// RAM holds {note, length} pairs that are played in order. Each note code maps to
// a 32-bit phase delta. A hold/linear-decay envelope restarts on every note.
//
// Note codes (6 bit):
//   0       rest (NOTE_RST), phase delta 0
//   1..60   C4..B8 in semitone order: code-1 = semitone + 12*(octave-4)
//   61..63  unused, treated as rest
// Phase deltas assume a 25 MHz NCO clock: delta = f * 2^32 / 25e6. Octave 4 is
// stored in a table, and each higher octave doubles the delta.
//
// Ports:
//   i_clk, i_rst_n                    clock, async active-low reset
//   i_wr_en/addr/note/len             step RAM write port
//   i_num_steps                       index of the last step played (clamped)
//   i_loop                            wrap to step 0 after the last step
//   i_start, i_stop                   start pulse (restarts in PLAY), stop pulse (wins)
//   o_busy                            high while playing
//   o_step                            current step index
//   o_new_note                        1-cycle pulse when a note starts
//   o_top, o_top_valid                constant PWM top value
//   o_phase_delta                     phase delta of the current note
//   o_envelope                        current envelope level
module pwm_note_sequencer_n #(
    parameter int          NUM_STEPS       = 16,
    parameter int          LEN_W           = 5,
    parameter int          CLOCKS_PER_TICK = 415_667,
    parameter int          ENV_W           = 9,
    parameter int          ENV_PEAK        = 14,
    parameter int          ENV_HOLD        = 7,
    parameter int          ENV_DECAY       = 12,
    parameter logic [7:0]  TOP             = 8'hff,
    localparam int         AW              = $clog2(NUM_STEPS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [5:0]        i_wr_note,
    input  logic [LEN_W-1:0]  i_wr_len,
    input  logic [AW-1:0]     i_num_steps,
    input  logic              i_loop,
    input  logic              i_start,
    input  logic              i_stop,
    output logic              o_busy,
    output logic [AW-1:0]     o_step,
    output logic              o_new_note,
    output logic [7:0]        o_top,
    output logic              o_top_valid,
    output logic [31:0]       o_phase_delta,
    output logic [ENV_W-1:0]  o_envelope
);

    localparam logic [5:0]    NOTE_RST = 6'd0;
    localparam int            CW       = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_TICK - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_STEPS - 1);

    typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

    function automatic logic [31:0] note_delta(input logic [5:0] code);
        logic [5:0]  idx;
        logic [5:0]  rem;
        logic [2:0]  oct;
        logic [31:0] base;
        if (code == NOTE_RST || code > 6'd60) return 32'd0;
        idx = code - 6'd1;
        if      (idx >= 6'd48) begin oct = 3'd4; rem = idx - 6'd48; end
        else if (idx >= 6'd36) begin oct = 3'd3; rem = idx - 6'd36; end
        else if (idx >= 6'd24) begin oct = 3'd2; rem = idx - 6'd24; end
        else if (idx >= 6'd12) begin oct = 3'd1; rem = idx - 6'd12; end
        else                   begin oct = 3'd0; rem = idx;         end
        case (rem[3:0])
            4'd0:    base = 32'd44948;  // C4
            4'd1:    base = 32'd47620;
            4'd2:    base = 32'd50452;
            4'd3:    base = 32'd53452;
            4'd4:    base = 32'd56630;
            4'd5:    base = 32'd59997;
            4'd6:    base = 32'd63565;
            4'd7:    base = 32'd67344;
            4'd8:    base = 32'd71349;
            4'd9:    base = 32'd75591;  // A4
            4'd10:   base = 32'd80086;
            default: base = 32'd84849;  // B4
        endcase
        return base << oct;
    endfunction

    // Step RAM, not reset
    logic [5+LEN_W:0]   r_ram [NUM_STEPS];

    state_t             r_state, w_state_nx;
    logic [AW-1:0]      r_step;
    logic [5:0]         r_note;
    logic [LEN_W-1:0]   r_len;
    logic [CW-1:0]      r_clk_cnt;
    logic [LEN_W-1:0]   r_tick;
    logic [ENV_W-1:0]   r_env;
    logic               r_new_note;

    logic               w_tick;
    logic               w_note_end;
    logic [AW-1:0]      w_last;
    logic               w_load;
    logic [AW-1:0]      w_load_addr;
    logic [5+LEN_W:0]   w_rd;
    logic [5:0]         w_rd_note;
    logic [LEN_W-1:0]   w_rd_len;

    always_ff @(posedge i_clk) begin
        if (i_wr_en && int'(i_wr_addr) < NUM_STEPS)
            r_ram[i_wr_addr] <= {i_wr_note, i_wr_len};
    end

    // Same-cycle write to the step being loaded bypasses the array so the new data is used
    assign w_rd      = (i_wr_en && i_wr_addr == w_load_addr) ? {i_wr_note, i_wr_len}
                                                             : r_ram[w_load_addr];
    assign w_rd_note = w_rd[5+LEN_W:LEN_W];
    assign w_rd_len  = w_rd[LEN_W-1:0];

    assign w_last     = (i_num_steps > IDX_LAST) ? IDX_LAST : i_num_steps;
    assign w_tick     = (r_clk_cnt == CNT_LAST);
    assign w_note_end = (r_state == S_PLAY) && w_tick && (r_tick == r_len);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_load_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nx = S_PLAY;
                    w_load     = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_stop) begin
                    w_state_nx = S_IDLE;
                end else if (i_start) begin
                    w_load = 1'b1;
                end else if (w_note_end) begin
                    if (r_step != w_last) begin
                        w_load      = 1'b1;
                        w_load_addr = r_step + 1'b1;
                    end else if (i_loop) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step     <= '0;
            r_note     <= NOTE_RST;
            r_len      <= '0;
            r_clk_cnt  <= '0;
            r_tick     <= '0;
            r_env      <= '0;
            r_new_note <= 1'b0;
        end else begin
            r_new_note <= w_load;
            if (w_load) begin
                r_step    <= w_load_addr;
                r_note    <= w_rd_note;
                r_len     <= w_rd_len;
                r_clk_cnt <= '0;
                r_tick    <= '0;
                r_env     <= (w_rd_note == NOTE_RST) ? '0 : ENV_W'(ENV_PEAK);
            end else if (w_state_nx == S_IDLE) begin
                r_note    <= NOTE_RST;
                r_clk_cnt <= '0;
                r_tick    <= '0;
                r_env     <= '0;
            end else if (w_tick) begin
                r_clk_cnt <= '0;
                r_tick    <= r_tick + 1'b1;
                // Decay starts on entry to tick ENV_HOLD and saturates at 0
                if (int'(r_tick) + 1 >= ENV_HOLD)
                    r_env <= (r_env > ENV_W'(ENV_DECAY)) ? r_env - ENV_W'(ENV_DECAY) : '0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

    assign o_busy        = (r_state == S_PLAY);
    assign o_step        = r_step;
    assign o_new_note    = r_new_note;
    assign o_top         = TOP;
    assign o_top_valid   = 1'b1;
    assign o_phase_delta = note_delta(r_note);
    assign o_envelope    = (r_state == S_PLAY && r_note != NOTE_RST) ? r_env : '0;

endmodule
